// File: rtl/wb_write_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Holds requester indices, the x0 address and the pointer-advance helper.
package wb_write_arbiter_pkg;

    localparam int SRC_ALU  = 0;
    localparam int SRC_LOAD = 1;
    localparam int SRC_CSR  = 2;

    localparam int X0_ADDR = 0;

    // Round-robin successor of a granted index among n requesters.
    function automatic int nextPtr(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping around, returned as a one-hot grant plus its index.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          valid
);

    int j;

    // Walk offsets from ptr so the first hit is the highest-priority requester.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!valid && req[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Round-robin arbiter for the single register-file write port; registers the
// winning write for one cycle and counts writes that actually reach the file.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int N     = 3,
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int CW    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*AW-1:0]      addr,
    input  logic [N*WIDTH-1:0]   data,
    input  logic                 stall,
    output logic [N-1:0]         gnt,
    output logic                 rf_wen,
    output logic [AW-1:0]        rf_waddr,
    output logic [WIDTH-1:0]     rf_wdata,
    output logic [CW-1:0]        wr_count
);

    localparam int PW = $clog2(N);

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    pickIdx;
    logic [N-1:0]     pickGnt;
    logic             pickValid;
    logic             transfer;
    logic             realWrite;
    logic [AW-1:0]    grantAddr;
    logic [WIDTH-1:0] grantData;

    rr_pick #(.N(N), .PW(PW)) uPick (
        .req   (req),
        .ptr   (ptr),
        .gnt   (pickGnt),
        .idx   (pickIdx),
        .valid (pickValid)
    );

    // Stall only gates the grant; the pick itself never sees it.
    assign gnt       = stall ? '0 : pickGnt;
    assign transfer  = pickValid & ~stall;
    assign grantAddr = addr[int'(pickIdx)*AW +: AW];
    assign grantData = data[int'(pickIdx)*WIDTH +: WIDTH];
    assign realWrite = transfer && (grantAddr != AW'(X0_ADDR));

    // Writes to x0 are consumed and advance ptr but never raise rf_wen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wr_count <= '0;
        end else begin
            rf_wen <= realWrite;
            if (transfer) begin
                ptr      <= PW'(nextPtr(int'(pickIdx), N));
                rf_waddr <= grantAddr;
                rf_wdata <= grantData;
            end
            if (realWrite)
                wr_count <= wr_count + CW'(1);
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter (N=3, CW=4 for short wrap).
module tb_wb_write_arbiter;

    localparam int N     = 3;
    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int CW    = 4;

    logic               clk;
    logic               reset;
    logic [N-1:0]       req;
    logic [N*AW-1:0]    addr;
    logic [N*WIDTH-1:0] data;
    logic               stall;
    logic [N-1:0]       gnt;
    logic               rf_wen;
    logic [AW-1:0]      rf_waddr;
    logic [WIDTH-1:0]   rf_wdata;
    logic [CW-1:0]      wr_count;

    int testCount;
    int failCount;

    wb_write_arbiter #(.N(N), .WIDTH(WIDTH), .AW(AW), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .addr     (addr),
        .data     (data),
        .stall    (stall),
        .gnt      (gnt),
        .rf_wen   (rf_wen),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [N-1:0] r,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [AW-1:0] a2,
                                 input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                                 input logic [WIDTH-1:0] d2, input logic s);
        req   = r;
        addr  = {a2, a1, a0};
        data  = {d2, d1, d0};
        stall = s;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        reset = 1'b1;
        req   = '0;
        addr  = '0;
        data  = '0;
        stall = 1'b0;
        #3;
        checkOutput("reset_wen",   32'(rf_wen),   32'd0);
        checkOutput("reset_waddr", 32'(rf_waddr), 32'd0);
        checkOutput("reset_wdata", rf_wdata,      32'd0);
        checkOutput("reset_count", 32'(wr_count), 32'd0);
        doReset();

        // Single request, one-cycle latency to the write port.
        applyStimulus(3'b001, 5'd5, 5'd0, 5'd0, 32'd15, 32'd0, 32'd0, 1'b0);
        checkOutput("single_gnt", 32'(gnt), 32'b001);
        tick();
        checkOutput("single_wen",   32'(rf_wen),   32'd1);
        checkOutput("single_waddr", 32'(rf_waddr), 32'd5);
        checkOutput("single_wdata", rf_wdata,      32'd15);
        checkOutput("single_count", 32'(wr_count), 32'd1);

        // All three requesting from reset: 001, 010, 100, back to 001.
        doReset();
        applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 32'd30, 1'b0);
        checkOutput("rr_gnt0", 32'(gnt), 32'b001);
        tick();
        checkOutput("rr_wen0",   32'(rf_wen),   32'd1);
        checkOutput("rr_waddr0", 32'(rf_waddr), 32'd1);
        checkOutput("rr_gnt1",   32'(gnt),      32'b010);
        tick();
        checkOutput("rr_wen1",   32'(rf_wen),   32'd1);
        checkOutput("rr_wdata1", rf_wdata,      32'd20);
        checkOutput("rr_gnt2",   32'(gnt),      32'b100);
        tick();
        checkOutput("rr_wen2",   32'(rf_wen),   32'd1);
        checkOutput("rr_waddr2", 32'(rf_waddr), 32'd3);
        checkOutput("rr_count",  32'(wr_count), 32'd3);
        checkOutput("rr_wrap",   32'(gnt),      32'b001);

        // Grant source 0 once more so ptr = 1, then skip the idle source 1.
        tick();
        checkOutput("skip_count0", 32'(wr_count), 32'd4);
        applyStimulus(3'b101, 5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 32'd30, 1'b0);
        checkOutput("skip_gnt0", 32'(gnt), 32'b100);
        tick();
        checkOutput("skip_waddr0", 32'(rf_waddr), 32'd3);
        checkOutput("skip_gnt1",   32'(gnt),      32'b001);
        tick();
        checkOutput("skip_waddr1", 32'(rf_waddr), 32'd1);
        checkOutput("skip_count1", 32'(wr_count), 32'd6);
        checkOutput("skip_gnt2",   32'(gnt),      32'b100);

        // x0 write from source 1 (ptr = 1): consumed, not written, ptr -> 2.
        applyStimulus(3'b010, 5'd1, 5'd0, 5'd3, 32'd10, 32'd30, 32'd30, 1'b0);
        checkOutput("x0_gnt", 32'(gnt), 32'b010);
        tick();
        checkOutput("x0_wen",   32'(rf_wen),   32'd0);
        checkOutput("x0_count", 32'(wr_count), 32'd6);
        applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 32'd30, 1'b0);
        checkOutput("x0_ptr", 32'(gnt), 32'b100);

        // Stall for two cycles with everyone requesting; ptr must stay at 2.
        applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 32'd30, 1'b1);
        checkOutput("stall_gnt0", 32'(gnt), 32'b000);
        tick();
        checkOutput("stall_wen0", 32'(rf_wen), 32'd0);
        checkOutput("stall_gnt1", 32'(gnt),    32'b000);
        tick();
        checkOutput("stall_wen1",  32'(rf_wen),   32'd0);
        checkOutput("stall_count", 32'(wr_count), 32'd6);
        applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 32'd30, 1'b0);
        checkOutput("stall_resume", 32'(gnt), 32'b100);

        // Counter wrap without reset: 6 + 9 = 15, then one more wraps to 0.
        applyStimulus(3'b001, 5'd7, 5'd0, 5'd0, 32'd77, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        checkOutput("wrap_pre", 32'(wr_count), 32'd15);
        tick();
        checkOutput("wrap_zero", 32'(wr_count), 32'd0);
        checkOutput("wrap_wen",  32'(rf_wen),   32'd1);

        // Reach 15 again, then assert reset between edges.
        for (int i = 0; i < 15; i++) tick();
        checkOutput("areset_pre_count", 32'(wr_count), 32'd15);
        checkOutput("areset_pre_wen",   32'(rf_wen),   32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("areset_wen",   32'(rf_wen),   32'd0);
        checkOutput("areset_waddr", 32'(rf_waddr), 32'd0);
        checkOutput("areset_wdata", rf_wdata,      32'd0);
        checkOutput("areset_count", 32'(wr_count), 32'd0);
        checkOutput("areset_gnt",   32'(gnt),      32'b001);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
